dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 4096, meaning number of 32-bit words of backing RAM (power of two).
REQ-002 Parameter AW, default 12, meaning RAM index width, equal to log2(DEPTH).
REQ-003 clock  input  1  master clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 address_dmem  input  32  word address from processor XM stage.
REQ-006 data  input  32  store data.
REQ-007 wren  input  1  store enable.
REQ-008 q_dmem  output  32  registered load data.
REQ-009 led_out  output  16  MMIO output register.
REQ-010 bus_error  output  1  sticky out-of-range access flag.

Function
REQ-011 Addressing SHALL be by word; address_dmem < DEPTH SHALL select RAM word address_dmem[AW-1:0].
REQ-012 A store (wren=1, address in RAM range) SHALL update RAM at the posedge where wren is sampled.
REQ-013 q_dmem SHALL be registered: the value for the address sampled at edge N SHALL appear after edge N and hold until edge N+1 (one-cycle latency), every cycle regardless of wren.
REQ-014 Read and write to the same address at the same edge SHALL be write-first: q_dmem SHALL return the new data.
REQ-015 MMIO addresses: 0xFFFFFFF0 CYCLE (read-only), 0xFFFFFFF4 LED (read/write, low 16 bits), 0xFFFFFFF8 SCRATCH (read/write, 32 bits).
REQ-016 CYCLE SHALL increment by 1 every clock not in reset, wrapping 0xFFFFFFFF -> 0; writes to CYCLE SHALL be ignored without setting bus_error.
REQ-017 An LED read SHALL return {16'b0, led_out}; an LED write SHALL load data[15:0] into led_out.
REQ-018 MMIO reads SHALL be write-first, identical to RAM reads.
REQ-019 Any other address (not RAM, not MMIO) SHALL make q_dmem 0 and ignore the write.
REQ-020 Such an access SHALL set bus_error only when wren=1 or the address differs from the previous cycle's, so an idle pipeline bubble at address 0 never flags.
REQ-021 bus_error SHALL remain 1 until reset.

Reset
REQ-022 While reset=1 at a posedge: q_dmem, led_out, bus_error, CYCLE and SCRATCH SHALL become 0.
REQ-023 While reset=1, stores SHALL be ignored.
REQ-024 RAM contents SHALL be retained across reset and not cleared.
REQ-025 CYCLE SHALL read 0 on the first edge after reset deasserts, then count.

Configuration
REQ-026 Macro DMEM_MMIO_EN defined: the MMIO region, led_out behaviour and CYCLE/SCRATCH SHALL be present as specified.
REQ-027 DMEM_MMIO_EN undefined: MMIO addresses SHALL be treated as out-of-range (REQ-019/020); led_out SHALL be tied 0; no counter or MMIO registers SHALL be synthesized.

Structure
REQ-028 Package dmem_pkg SHALL hold the MMIO address constants (CYCLE_ADDR, LED_ADDR, SCRATCH_ADDR) and the DEPTH default.
REQ-029 The MMIO registers and the cycle counter SHALL live in one sub-module, dmem_mmio_regs.
REQ-030 dmem_mmio_regs SHALL be instantiated only under DMEM_MMIO_EN.
REQ-031 RAM and the read mux SHALL remain in dmem_responder.

Verification
REQ-032 Store addr 5 data 0xDEADBEEF, next cycle load addr 5 -> q_dmem 0xDEADBEEF one cycle after the address is sampled.
REQ-033 Same edge: wren=1, addr 7, data 0x12345678 -> q_dmem after that edge is 0x12345678 (write-first).
REQ-034 Release reset, idle 10 cycles, load 0xFFFFFFF0 -> q_dmem 10 (±1 per the documented sample edge); preload the counter to 0xFFFFFFFF by force -> next read 0.
REQ-035 Store 0xABCD1234 to 0xFFFFFFF4 -> led_out 0x1234, read back 0x00001234; with DMEM_MMIO_EN undefined -> led_out 0 and bus_error 1.
REQ-036 Store to address DEPTH (4096) -> RAM unchanged, q_dmem 0, bus_error 1; assert reset -> bus_error 0, and RAM word 5 still 0xDEADBEEF.
REQ-037 Assert reset mid-store-stream (wren=1, addr 9) -> addr 9 unmodified, all outputs 0 after the reset edge.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and MMIO decode for dmem_responder and dmem_mmio_regs.
// The MMIO block is built only when DMEM_MMIO_EN is defined.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH = 4096;

  localparam logic [31:0] CYCLE_ADDR   = 32'hFFFF_FFF0;
  localparam logic [31:0] LED_ADDR     = 32'hFFFF_FFF4;
  localparam logic [31:0] SCRATCH_ADDR = 32'hFFFF_FFF8;

  typedef enum logic [1:0] {
    MMIO_NONE,
    MMIO_CYCLE,
    MMIO_LED,
    MMIO_SCRATCH
  } mmio_sel_e;

  function automatic mmio_sel_e mmio_decode(input logic [31:0] addr);
    case (addr)
      CYCLE_ADDR:   return MMIO_CYCLE;
      LED_ADDR:     return MMIO_LED;
      SCRATCH_ADDR: return MMIO_SCRATCH;
      default:      return MMIO_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_mmio_regs.sv
// Memory-mapped registers: free-running CYCLE counter, LED output and SCRATCH.
// Instantiated by dmem_responder only when DMEM_MMIO_EN is defined.
module dmem_mmio_regs
  import dmem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic [31:0] i_data,
  input  logic        i_wren,
  output logic        o_hit,
  output logic [31:0] o_rdata,
  output logic [15:0] o_led
);

  mmio_sel_e   w_sel;
  logic [31:0] r_cycle;
  logic [31:0] r_scratch;
  logic [15:0] r_led;

  assign w_sel = mmio_decode(i_address);
  assign o_hit = (w_sel != MMIO_NONE);
  assign o_led = r_led;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycle   <= '0;
      r_led     <= '0;
      r_scratch <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (i_wren && (w_sel == MMIO_LED))     r_led     <= i_data[15:0];
      if (i_wren && (w_sel == MMIO_SCRATCH)) r_scratch <= i_data;
    end
  end

  // Write-first read: a store on the same edge is returned instead of the old value.
  always_comb begin
    o_rdata = '0;
    case (w_sel)
      MMIO_CYCLE:   o_rdata = r_cycle;
      MMIO_LED:     o_rdata = {16'h0000, (i_wren ? i_data[15:0] : r_led)};
      MMIO_SCRATCH: o_rdata = i_wren ? i_data : r_scratch;
      default:      o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory with registered write-first reads, sticky bus error
// and optional MMIO region (define DMEM_MMIO_EN to build CYCLE/LED/SCRATCH).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned AW    = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [15:0] led_out,
  output logic        bus_error
);

  logic [31:0]   r_ram [DEPTH];
  logic [31:0]   r_q_dmem;
  logic [31:0]   r_prev_addr;
  logic          r_bus_error;

  logic          w_ram_hit;
  logic          w_ram_we;
  logic [AW-1:0] w_idx;
  logic          w_mmio_hit;
  logic [31:0]   w_mmio_rdata;
  logic [31:0]   w_rdata;
  logic          w_out_of_range;
  logic          w_flag;

  assign w_ram_hit = ((address_dmem >> AW) == 32'd0);
  assign w_idx     = address_dmem[AW-1:0];
  assign w_ram_we  = wren && w_ram_hit && !reset;

`ifdef DMEM_MMIO_EN
  dmem_mmio_regs u_mmio (
    .clock     (clock),
    .reset     (reset),
    .i_address (address_dmem),
    .i_data    (data),
    .i_wren    (wren),
    .o_hit     (w_mmio_hit),
    .o_rdata   (w_mmio_rdata),
    .o_led     (led_out)
  );
`else
  assign w_mmio_hit   = 1'b0;
  assign w_mmio_rdata = '0;
  assign led_out      = '0;
`endif

  // NOTE: the RAM has no reset branch; its contents must survive reset and it maps to block RAM.
  always_ff @(posedge clock) begin
    if (w_ram_we) r_ram[w_idx] <= data;
  end

  always_comb begin
    // NOTE: default first so no path through this block leaves w_rdata unassigned (no latch).
    w_rdata = '0;
    if (w_ram_hit) begin
      w_rdata = wren ? data : r_ram[w_idx];
    end else if (w_mmio_hit) begin
      w_rdata = w_mmio_rdata;
    end
  end

  // A held out-of-range read (idle bubble) does not flag; a new address or a store does.
  assign w_out_of_range = !w_ram_hit && !w_mmio_hit;
  assign w_flag         = w_out_of_range && (wren || (address_dmem != r_prev_addr));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q_dmem    <= '0;
      r_prev_addr <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_q_dmem    <= w_rdata;
      r_prev_addr <= address_dmem;
      if (w_flag) r_bus_error <= 1'b1;
    end
  end

  assign q_dmem    = r_q_dmem;
  assign bus_error = r_bus_error;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized traffic
// compared every cycle against a behavioural memory/MMIO model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic [15:0] led_out;
  logic        bus_error;

  dmem_responder #(.DEPTH(DEPTH), .AW(12)) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .led_out      (led_out),
    .bus_error    (bus_error)
  );

  always #5 clock = ~clock;

`ifdef DMEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Behavioural model state
  logic [31:0] m_mem [int unsigned];
  logic [31:0] m_cycle   = '0;
  logic [31:0] m_scratch = '0;
  logic [31:0] m_prev    = '0;
  logic [31:0] exp_q     = '0;
  logic [15:0] exp_led   = '0;
  logic        exp_berr  = 1'b0;
  logic        exp_q_known = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one sampled edge's worth of the rules to the model.
  task automatic model_step();
    logic [31:0] a;
    a = address_dmem;
    if (reset) begin
      exp_q = '0; exp_q_known = 1'b1;
      exp_led = '0; exp_berr = 1'b0;
      m_cycle = '0; m_scratch = '0; m_prev = '0;
    end else begin
      exp_q_known = 1'b1;
      if (a < DEPTH) begin
        if (wren) m_mem[a] = data;
        exp_q_known = m_mem.exists(a) ? 1'b1 : 1'b0;
        exp_q = exp_q_known ? m_mem[a] : '0;
      end else if (MMIO_EN && a == CYCLE_ADDR) begin
        exp_q = m_cycle;
      end else if (MMIO_EN && a == LED_ADDR) begin
        if (wren) exp_led = data[15:0];
        exp_q = {16'h0000, exp_led};
      end else if (MMIO_EN && a == SCRATCH_ADDR) begin
        if (wren) m_scratch = data;
        exp_q = m_scratch;
      end else begin
        exp_q = '0;
        if (wren || a != m_prev) exp_berr = 1'b1;
      end
      m_cycle = m_cycle + 32'd1;
      m_prev  = a;
    end
  endtask

  task automatic compare();
    if (exp_q_known) check("q_dmem", q_dmem, exp_q);
    check("led_out", {16'h0000, led_out}, {16'h0000, exp_led});
    check("bus_error", {31'h0, bus_error}, {31'h0, exp_berr});
  endtask

  // Drive inputs after a falling edge, model the rising edge, compare on the next falling edge.
  task automatic tick(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rst);
    address_dmem = a;
    data         = d;
    wren         = we;
    reset        = rst;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] last_a;
    int          sel;

    // Reset state
    tick(32'h0, 32'h0, 1'b0, 1'b1);
    tick(32'h0, 32'h0, 1'b0, 1'b1);
    check("reset_q", q_dmem, 32'h0);
    check("reset_led", {16'h0000, led_out}, 32'h0);
    check("reset_berr", {31'h0, bus_error}, 32'h0);

    // Counter: 10 idle edges after reset, then read CYCLE
    repeat (10) tick(32'h0, 32'h0, 1'b0, 1'b0);
    check("idle_no_berr", {31'h0, bus_error}, 32'h0);
    tick(CYCLE_ADDR, 32'h0, 1'b0, 1'b0);
`ifdef DMEM_MMIO_EN
    check("cycle_after_10", q_dmem, 32'd10);
    tick(CYCLE_ADDR, 32'h5555_5555, 1'b1, 1'b0);
    check("cycle_write_ignored", q_dmem, 32'd11);
    check("cycle_write_no_berr", {31'h0, bus_error}, 32'h0);
    force dut.u_mmio.r_cycle = 32'hFFFF_FFFF;
    #1;
    release dut.u_mmio.r_cycle;
    m_cycle = 32'hFFFF_FFFF;
    tick(CYCLE_ADDR, 32'h0, 1'b0, 1'b0);
    check("cycle_preload", q_dmem, 32'hFFFF_FFFF);
    tick(CYCLE_ADDR, 32'h0, 1'b0, 1'b0);
    check("cycle_wrap", q_dmem, 32'h0);
`else
    check("cycle_oor_q", q_dmem, 32'h0);
    check("cycle_oor_berr", {31'h0, bus_error}, 32'h1);
`endif
    tick(32'h0, 32'h0, 1'b0, 1'b1);

    // Store then load, and same-edge write-first
    tick(32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tick(32'd5, 32'h0, 1'b0, 1'b0);
    check("store_load_5", q_dmem, 32'hDEAD_BEEF);
    tick(32'd7, 32'h1234_5678, 1'b1, 1'b0);
    check("write_first_7", q_dmem, 32'h1234_5678);

    // LED register
    tick(LED_ADDR, 32'hABCD_1234, 1'b1, 1'b0);
`ifdef DMEM_MMIO_EN
    check("led_store", {16'h0000, led_out}, 32'h0000_1234);
    check("led_write_first", q_dmem, 32'h0000_1234);
    tick(LED_ADDR, 32'h0, 1'b0, 1'b0);
    check("led_readback", q_dmem, 32'h0000_1234);
    tick(SCRATCH_ADDR, 32'hCAFE_F00D, 1'b1, 1'b0);
    tick(SCRATCH_ADDR, 32'h0, 1'b0, 1'b0);
    check("scratch_readback", q_dmem, 32'hCAFE_F00D);
`else
    check("led_disabled", {16'h0000, led_out}, 32'h0);
    check("led_disabled_berr", {31'h0, bus_error}, 32'h1);
`endif
    tick(32'h0, 32'h0, 1'b0, 1'b1);

    // Out-of-range store at DEPTH must not alias onto word 0
    tick(32'd0, 32'h1111_1111, 1'b1, 1'b0);
    tick(32'd4096, 32'h5555_5555, 1'b1, 1'b0);
    check("oor_q", q_dmem, 32'h0);
    check("oor_berr", {31'h0, bus_error}, 32'h1);
    tick(32'd0, 32'h0, 1'b0, 1'b0);
    check("oor_no_alias", q_dmem, 32'h1111_1111);
    tick(32'd0, 32'h0, 1'b0, 1'b1);
    check("berr_cleared", {31'h0, bus_error}, 32'h0);
    tick(32'd5, 32'h0, 1'b0, 1'b0);
    check("ram_kept_5", q_dmem, 32'hDEAD_BEEF);

    // Reset in the middle of a store stream
    tick(32'd9, 32'hA5A5_A5A5, 1'b1, 1'b0);
    tick(32'd9, 32'hFFFF_0000, 1'b1, 1'b1);
    check("rst_stream_q", q_dmem, 32'h0);
    check("rst_stream_led", {16'h0000, led_out}, 32'h0);
    check("rst_stream_berr", {31'h0, bus_error}, 32'h0);
    tick(32'd9, 32'h0, 1'b0, 1'b0);
    check("rst_stream_kept_9", q_dmem, 32'hA5A5_A5A5);

    // Randomized traffic against the model
    last_a = 32'h0;
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1, 2, 3, 4: ra = $urandom_range(0, 15);
        5:             ra = $urandom_range(4094, 4097);
        6:             ra = CYCLE_ADDR;
        7:             ra = LED_ADDR;
        8:             ra = SCRATCH_ADDR;
        9:             ra = 32'hFFFF_FFFC;
        10:            ra = $urandom | 32'h0010_0000;
        default:       ra = last_a;
      endcase
      tick(ra, $urandom, ($urandom_range(0, 1) == 1), ($urandom_range(0, 39) == 0));
      last_a = ra;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
